// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one byte-wide UART transmitter
// between NUM_REQ requesters, with up to MAX_BURST bytes per grant.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   req_valid      per-requester byte available
//   req_data       per-requester byte, requester k at [k*PAYLOAD_BITS +: PAYLOAD_BITS]
//   req_last       per-requester end-of-packet flag
//   req_ready      one-hot acceptance, high only together with uart_tx_en
//   uart_tx_busy   shared transmitter busy flag
//   uart_tx_en     single-cycle transmit strobe
//   uart_tx_data   byte being transmitted, valid while uart_tx_en=1
//   grant_id       current or most recent grant holder
//   grant_active   a requester currently holds the grant
//
// Optional feature: define UART_TX_ARB_PRIO_EN to give requester 0 absolute
// priority at arbitration; the remaining requesters stay round-robin.
//
// All outputs are registered. The strobe, ready and data for a SEND cycle
// are computed on the edge that enters SEND (from ARB or WAIT_LO), so the
// strobe is visible during the SEND cycle itself and the IDLE->ARB->SEND
// latency is two cycles. SEND entered without a strobe means the requester
// had nothing to send, and the grant is dropped.
module uart_tx_arb #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned MAX_BURST    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            uart_tx_busy,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            grant_active
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned TO_W  = 2;
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
    localparam logic [TO_W-1:0]  TO_LAST   = '1;
    localparam logic [ID_W-1:0]  ID_RESET  = ID_W'(NUM_REQ - 1);

`ifdef UART_TX_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ARB, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t                  state_q, state_d;
    logic                    en_q, en_d;
    logic [NUM_REQ-1:0]      ready_q, ready_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic [ID_W-1:0]         gid_q, gid_d;
    logic                    act_q, act_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    last_q, last_d;
    logic [TO_W-1:0]         to_q, to_d;

    logic [PAYLOAD_BITS-1:0] data_arr_c [NUM_REQ];
    logic                    sel_found_c;
    logic [ID_W-1:0]         sel_id_c;
    logic [ID_W-1:0]         idx_c;
    logic                    strobe_c;
    logic [ID_W-1:0]         strobe_id_c;

    // Unpack the flat data bus into per-requester bytes
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign data_arr_c[k] = req_data[k*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    // Round-robin search starting one past the last grant holder
    always_comb begin
        sel_found_c = 1'b0;
        sel_id_c    = gid_q;
        idx_c       = '0;
        if (PRIO_EN && req_valid[0]) begin
            sel_found_c = 1'b1;
            sel_id_c    = '0;
        end else begin
            for (int unsigned i = 1; i <= NUM_REQ; i++) begin
                idx_c = ID_W'((32'(gid_q) + i) % NUM_REQ);
                if (!sel_found_c && req_valid[idx_c] && !(PRIO_EN && idx_c == '0)) begin
                    sel_found_c = 1'b1;
                    sel_id_c    = idx_c;
                end
            end
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        en_d        = 1'b0;
        ready_d     = '0;
        data_d      = data_q;
        gid_d       = gid_q;
        act_d       = act_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        to_d        = to_q;
        strobe_c    = 1'b0;
        strobe_id_c = gid_q;

        case (state_q)
            IDLE: begin
                if (|req_valid && !uart_tx_busy) state_d = ARB;
            end
            ARB: begin
                state_d = SEND;
                cnt_d   = '0;
                act_d   = sel_found_c;
                if (sel_found_c) begin
                    gid_d       = sel_id_c;
                    strobe_c    = 1'b1;
                    strobe_id_c = sel_id_c;
                end
            end
            SEND: begin
                if (en_q) begin
                    state_d = WAIT_HI;
                    to_d    = '0;
                end else begin
                    act_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            WAIT_HI: begin
                // Timeout keeps a never-busy transmitter from stalling us
                if (uart_tx_busy || to_q == TO_LAST) state_d = WAIT_LO;
                else                                 to_d    = to_q + TO_W'(1);
            end
            WAIT_LO: begin
                if (!uart_tx_busy) begin
                    if (!last_q && cnt_q < BURST_LIM && req_valid[gid_q]) begin
                        state_d     = SEND;
                        strobe_c    = 1'b1;
                        strobe_id_c = gid_q;
                    end else begin
                        act_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (strobe_c) begin
            en_d                 = 1'b1;
            ready_d[strobe_id_c] = 1'b1;
            data_d               = data_arr_c[strobe_id_c];
            last_d               = req_last[strobe_id_c];
            cnt_d                = (cnt_d == CNT_SAT) ? cnt_d : cnt_d + CNT_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            ready_q <= '0;
            data_q  <= '0;
            gid_q   <= ID_RESET;
            act_q   <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            to_q    <= to_d;
        end
    end

    assign uart_tx_en   = en_q;
    assign req_ready    = ready_q;
    assign uart_tx_data = data_q;
    assign grant_id     = gid_q;
    assign grant_active = act_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb (NUM_REQ=4, PAYLOAD_BITS=8, MAX_BURST=4).
// Requesters are fed from a pending-byte list; every transmit strobe is
// compared with a transaction-level arbitration model.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int PB = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N*PB-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            uart_tx_busy;
    logic            uart_tx_en;
    logic [PB-1:0]   uart_tx_data;
    logic [1:0]      grant_id;
    logic            grant_active;

    uart_tx_arb #(.NUM_REQ(N), .PAYLOAD_BITS(PB), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .grant_id     (grant_id),
        .grant_active (grant_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic       last;
        logic [7:0] data;
    } ent_t;

    ent_t pend[$];
    int   order[$];
    int   en_cycles[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busy_len = 0;
    int   busy_left = 0;
    int   m_ptr = N - 1;
    int   m_cnt = 0;
    bit   m_open = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int find_head(input int k);
        foreach (pend[i]) if (int'(pend[i].id) == k) return i;
        return -1;
    endfunction

    // Which requester the next strobe must belong to
    function automatic int predict();
        if (m_open && find_head(m_ptr) >= 0) return m_ptr;
`ifdef UART_TX_ARB_PRIO_EN
        if (find_head(0) >= 0) return 0;
`endif
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (m_ptr + i) % N;
`ifdef UART_TX_ARB_PRIO_EN
            if (idx == 0) continue;
`endif
            if (find_head(idx) >= 0) return idx;
        end
        return -1;
    endfunction

    task automatic add(input int k, input logic last, input logic [7:0] d);
        ent_t e;
        e.id = 2'(k); e.last = last; e.data = d;
        pend.push_back(e);
    endtask

    task automatic drive_reqs();
        logic [N-1:0]    v;
        logic [N-1:0]    l;
        logic [N*PB-1:0] d;
        v = '0; l = '0; d = '0;
        for (int k = 0; k < N; k++) begin
            int h;
            h = find_head(k);
            if (h >= 0) begin
                v[k] = 1'b1;
                l[k] = pend[h].last;
                d[k*PB +: PB] = pend[h].data;
            end
        end
        req_valid = v; req_last = l; req_data = d;
    endtask

    // One clock: sample after the edge, check, then update transmitter and requesters
    task automatic tick();
        logic bad;
        int   k;
        int   h;
        @(posedge clk); #1;
        cyc++;
        bad = (req_ready != '0) && !(uart_tx_en && $onehot(req_ready));
        check("ready_only_with_en", 32'(bad), 0);
        if (uart_tx_en) begin
            k = predict();
            order.push_back(int'(grant_id));
            en_cycles.push_back(cyc);
            if (k < 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                h = find_head(k);
                check("strobe_ready", 32'(req_ready), 32'(1) << k);
                check("strobe_grant_id", 32'(grant_id), k);
                check("strobe_data", 32'(uart_tx_data), 32'(pend[h].data));
                check("strobe_grant_active", 32'(grant_active), 1);
                m_cnt  = (m_open && k == m_ptr) ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 1;
                m_ptr  = k;
                m_open = !pend[h].last && m_cnt < MB;
                pend.delete(h);
            end
            busy_left = busy_len;
        end
        uart_tx_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        drive_reqs();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_rst_en"}, 32'(uart_tx_en), 0);
        check({tag, "_rst_ready"}, 32'(req_ready), 0);
        check({tag, "_rst_data"}, 32'(uart_tx_data), 0);
        check({tag, "_rst_active"}, 32'(grant_active), 0);
        check({tag, "_rst_gid"}, 32'(grant_id), N - 1);
        @(posedge clk); #1;
        reset = 1'b0;
        busy_left = 0; uart_tx_busy = 1'b0;
        m_ptr = N - 1; m_open = 1'b0; m_cnt = 0;
        drive_reqs();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (pend.size() > 0 && n < budget) begin tick(); n++; end
        check({tag, "_drained"}, 32'(pend.size()), 0);
        pend.delete();
        repeat (busy_len + 10) tick();
        check({tag, "_released"}, 32'(grant_active), 0);
        check({tag, "_gid_hold"}, 32'(grant_id), m_ptr);
        m_open = 1'b0;
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        check({tag, "_count"}, 32'(order.size()), 32'(exp.size()));
        foreach (exp[i]) if (i < order.size()) check($sformatf("%s_%0d", tag, i), order[i], exp[i]);
    endtask

    initial begin
        int   exp_q[$];
        int   start;
        int   n;
        req_valid = '0; req_data = '0; req_last = '0; uart_tx_busy = 1'b0;
        #2;
        do_reset("init");

        // Single requester, latency and data
        busy_len = 10; order.delete(); en_cycles.delete();
        add(2, 1'b1, 8'h41);
        drive_reqs();
        start = cyc;
        drain("single", 50);
        check("single_strobes", 32'(en_cycles.size()), 1);
        if (en_cycles.size() > 0) check("single_latency", en_cycles[0] - start, 2);

        // Fairness from reset
        do_reset("fair");
        busy_len = 2; order.delete();
        for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) add(k, 1'b1, 8'($urandom));
        drive_reqs();
        drain("fair", 300);
`ifdef UART_TX_ARB_PRIO_EN
        exp_q = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        check_order("fair_order", exp_q);

        // Burst cap of MAX_BURST, then rotation
        busy_len = 3; order.delete();
        for (int i = 0; i < 6; i++) add(1, 1'b0, 8'($urandom));
        add(3, 1'b1, 8'($urandom));
        drive_reqs();
        drain("burst", 400);
        exp_q = '{1, 1, 1, 1, 3, 1, 1};
        check_order("burst_order", exp_q);

        // Transmitter never busy: WAIT_HI timeout paces the burst
        busy_len = 0; order.delete(); en_cycles.delete();
        add(0, 1'b0, 8'h11); add(0, 1'b0, 8'h22); add(0, 1'b1, 8'h33);
        drive_reqs();
        drain("stuck", 200);
        check("stuck_strobes", 32'(en_cycles.size()), 3);
        if (en_cycles.size() == 3) begin
            check("stuck_gap0", en_cycles[1] - en_cycles[0], 6);
            check("stuck_gap1", en_cycles[2] - en_cycles[1], 6);
        end

        // Priority versus round-robin after a grant to requester 1
        busy_len = 1; order.delete();
        add(1, 1'b1, 8'h5a);
        drive_reqs();
        drain("pre_prio", 100);
        order.delete();
        add(0, 1'b1, 8'h01); add(2, 1'b1, 8'h02);
        drive_reqs();
        drain("prio", 100);
`ifdef UART_TX_ARB_PRIO_EN
        exp_q = '{0, 2};
`else
        exp_q = '{2, 0};
`endif
        check_order("prio_order", exp_q);

        // Reset while waiting for the transmitter to go idle
        busy_len = 10; en_cycles.delete();
        add(2, 1'b0, 8'hc3); add(2, 1'b1, 8'h3c);
        drive_reqs();
        n = 0;
        while (en_cycles.size() == 0 && n < 20) begin tick(); n++; end
        check("midrst_first_strobe", 32'(en_cycles.size()), 1);
        repeat (3) tick();
        add(0, 1'b1, 8'h77); add(1, 1'b1, 8'h88);
        #2;
        do_reset("midrst");
        order.delete();
        tick();
        check("midrst_no_strobe_after", 32'(uart_tx_en), 0);
        drain("midrst", 300);
        exp_q = '{0, 1, 2};
        check_order("midrst_order", exp_q);

        // Randomized traffic against the model
        for (int r = 0; r < 6; r++) begin
            busy_len = $urandom_range(0, 8);
            for (int k = 0; k < N; k++) begin
                int cnt;
                cnt = $urandom_range(0, 5);
                for (int i = 0; i < cnt; i++) add(k, ($urandom_range(0, 2) == 0), 8'($urandom));
            end
            drive_reqs();
            drain($sformatf("rand%0d", r), 2000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
